// File: rtl/mtl_frame_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : mtl_frame_monitor
//  Brief    : Measures MTL video timing (totals, active area, pixel checksum)
//             per frame and tracks lock to a stable, expected raster.
//  Revision : 1.0 - initial release
// ============================================================================
module mtl_frame_monitor #(
    parameter int EXP_H_ACTIVE = 800,
    parameter int EXP_V_ACTIVE = 480,
    parameter int LOCK_FRAMES  = 2,
    parameter int SYNC_ACT_LOW = 1,
    parameter int TIMEOUT_W    = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        de,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [11:0] h_total,
    output logic [11:0] v_total,
    output logic [10:0] h_active,
    output logic [10:0] v_active,
    output logic [31:0] pix_sum,
    output logic [15:0] frame_count,
    output logic        frame_done,
    output logic        locked,
    output logic        err
);

    localparam logic        c_SAL    = (SYNC_ACT_LOW != 0);
    localparam logic [10:0] c_EXP_H  = 11'(EXP_H_ACTIVE);
    localparam logic [10:0] c_EXP_V  = 11'(EXP_V_ACTIVE);
    localparam logic [3:0]  c_LOCK_N = 4'(LOCK_FRAMES);

    localparam logic [1:0]  c_ST_SEARCH  = 2'd0;
    localparam logic [1:0]  c_ST_MEASURE = 2'd1;
    localparam logic [1:0]  c_ST_LOCKED  = 2'd2;

    function automatic logic [11:0] f_sat12(input logic [11:0] v);
        return (&v) ? v : v + 12'd1;
    endfunction

    function automatic logic [10:0] f_sat11(input logic [10:0] v);
        return (&v) ? v : v + 11'd1;
    endfunction

    // ------------------------------------------------------------------
    // Sync normalisation and leading-edge detection
    // ------------------------------------------------------------------
    logic w_hs_a, w_vs_a;
    logic r_hs_prev, r_vs_prev, r_armed;
    logic w_hs_edge, w_vs_edge;

    assign w_hs_a = hs ^ c_SAL;
    assign w_vs_a = vs ^ c_SAL;

    // r_armed masks the first sample after reset so a sync held asserted
    // through reset release is not mistaken for a fresh leading edge.
    assign w_hs_edge = r_armed & w_hs_a & ~r_hs_prev;
    assign w_vs_edge = r_armed & w_vs_a & ~r_vs_prev;

    // Previous-sample registers for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_hs_prev <= w_hs_a;
            r_vs_prev <= w_vs_a;
            r_armed   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-line accumulation (clock count includes the HS edge cycle)
    // ------------------------------------------------------------------
    logic        r_line_open;
    logic [11:0] r_line_clk;
    logic [10:0] r_line_de;
    logic        w_line_close;

    assign w_line_close = w_hs_edge & r_line_open;

    // Line clock and DE counters, restarted on every HS leading edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_open <= 1'b0;
            r_line_clk  <= 12'd0;
            r_line_de   <= 11'd0;
        end else if (w_hs_edge) begin
            r_line_open <= 1'b1;
            r_line_clk  <= 12'd1;
            r_line_de   <= de ? 11'd1 : 11'd0;
        end else if (r_line_open) begin
            r_line_clk <= f_sat12(r_line_clk);
            if (de) begin
                r_line_de <= f_sat11(r_line_de);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-frame accumulation
    // ------------------------------------------------------------------
    logic [11:0] r_f_htot, r_f_vtot;
    logic [10:0] r_f_hact, r_f_vact;
    logic        r_f_have_clk, r_f_have_de, r_f_bad;
    logic [31:0] r_f_sum;

    // Frame statistics with the closing line (if any) folded in; these are
    // the values reported when a VS edge closes the frame in the same cycle.
    logic [11:0] w_cl_htot;
    logic [10:0] w_cl_hact, w_cl_vact;
    logic        w_cl_have_clk, w_cl_have_de, w_cl_bad;
    logic [31:0] w_pix;

    assign w_pix = {8'h00, r, g, b};

    // Fold a closing line into the running frame statistics
    always_comb begin
        w_cl_htot     = r_f_htot;
        w_cl_hact     = r_f_hact;
        w_cl_vact     = r_f_vact;
        w_cl_have_clk = r_f_have_clk;
        w_cl_have_de  = r_f_have_de;
        w_cl_bad      = r_f_bad;
        if (w_line_close) begin
            if (r_f_have_clk && (r_line_clk != r_f_htot)) begin
                w_cl_bad = 1'b1;
            end
            w_cl_htot     = r_line_clk;
            w_cl_have_clk = 1'b1;
            if (r_line_de != 11'd0) begin
                if (r_f_have_de && (r_line_de != r_f_hact)) begin
                    w_cl_bad = 1'b1;
                end
                w_cl_hact    = r_line_de;
                w_cl_have_de = 1'b1;
                w_cl_vact    = f_sat11(r_f_vact);
            end
        end
    end

    // Frame accumulators; a VS edge restarts them for the new frame, and an
    // HS edge in that same cycle is the first line of the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f_htot     <= 12'd0;
            r_f_vtot     <= 12'd0;
            r_f_hact     <= 11'd0;
            r_f_vact     <= 11'd0;
            r_f_have_clk <= 1'b0;
            r_f_have_de  <= 1'b0;
            r_f_bad      <= 1'b0;
            r_f_sum      <= 32'd0;
        end else if (w_vs_edge) begin
            r_f_htot     <= 12'd0;
            r_f_vtot     <= w_hs_edge ? 12'd1 : 12'd0;
            r_f_hact     <= 11'd0;
            r_f_vact     <= 11'd0;
            r_f_have_clk <= 1'b0;
            r_f_have_de  <= 1'b0;
            r_f_bad      <= 1'b0;
            r_f_sum      <= de ? w_pix : 32'd0;
        end else begin
            r_f_htot     <= w_cl_htot;
            r_f_hact     <= w_cl_hact;
            r_f_vact     <= w_cl_vact;
            r_f_have_clk <= w_cl_have_clk;
            r_f_have_de  <= w_cl_have_de;
            r_f_bad      <= w_cl_bad;
            if (w_hs_edge) begin
                r_f_vtot <= f_sat12(r_f_vtot);
            end
            if (de) begin
                r_f_sum <= r_f_sum + w_pix;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame qualification and lock state machine
    // ------------------------------------------------------------------
    logic [1:0]  r_state, w_state_nx;
    logic [3:0]  r_match, w_match_nx;
    logic        r_err, w_err_nx;
    logic        w_ref_load;
    logic        r_ref_valid;
    logic [11:0] r_ref_htot, r_ref_vtot;
    logic [10:0] r_ref_hact, r_ref_vact;
    logic [TIMEOUT_W-1:0] r_to;
    logic        w_to_hit;
    logic        w_good, w_same_ref, w_close;

    assign w_good = ~w_cl_bad & (w_cl_hact == c_EXP_H) & (w_cl_vact == c_EXP_V);
    assign w_same_ref = r_ref_valid &
                        (w_cl_htot == r_ref_htot) & (r_f_vtot == r_ref_vtot) &
                        (w_cl_hact == r_ref_hact) & (w_cl_vact == r_ref_vact);
    assign w_close  = w_vs_edge & (r_state != c_ST_SEARCH);
    assign w_to_hit = &r_to;

    // Next-state, match counter and error flag decisions
    always_comb begin
        w_state_nx = r_state;
        w_match_nx = r_match;
        w_err_nx   = r_err;
        w_ref_load = 1'b0;
        case (r_state)
            c_ST_SEARCH: begin
                w_match_nx = 4'd0;
                if (w_vs_edge) begin
                    w_state_nx = c_ST_MEASURE;
                end
            end
            c_ST_MEASURE: begin
                if (w_vs_edge) begin
                    if (w_good) begin
                        w_ref_load = 1'b1;
                        if (w_same_ref) begin
                            w_match_nx = (&r_match) ? r_match : r_match + 4'd1;
                        end else begin
                            w_match_nx = 4'd1;
                        end
                        if (w_match_nx >= c_LOCK_N) begin
                            w_state_nx = c_ST_LOCKED;
                        end
                    end else begin
                        w_match_nx = 4'd0;
                    end
                end else if (w_to_hit) begin
                    w_state_nx = c_ST_SEARCH;
                    w_match_nx = 4'd0;
                end
            end
            c_ST_LOCKED: begin
                if (w_vs_edge) begin
                    // The reference stays frozen at the locking frame.
                    if (!w_good || !w_same_ref) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = c_ST_MEASURE;
                        w_match_nx = 4'd0;
                    end
                end else if (w_to_hit) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = c_ST_SEARCH;
                    w_match_nx = 4'd0;
                end
            end
            default: begin
                w_state_nx = c_ST_SEARCH;
                w_match_nx = 4'd0;
            end
        endcase
    end

    // State, match counter, sticky error and lock reference registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_SEARCH;
            r_match     <= 4'd0;
            r_err       <= 1'b0;
            r_ref_valid <= 1'b0;
            r_ref_htot  <= 12'd0;
            r_ref_vtot  <= 12'd0;
            r_ref_hact  <= 11'd0;
            r_ref_vact  <= 11'd0;
        end else begin
            r_state <= w_state_nx;
            r_match <= w_match_nx;
            r_err   <= w_err_nx;
            if (w_ref_load) begin
                r_ref_valid <= 1'b1;
                r_ref_htot  <= w_cl_htot;
                r_ref_vtot  <= r_f_vtot;
                r_ref_hact  <= w_cl_hact;
                r_ref_vact  <= w_cl_vact;
            end
        end
    end

    // Watchdog counting clocks since the last VS edge while measuring/locked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to <= '0;
        end else if ((r_state == c_ST_SEARCH) || w_vs_edge || w_to_hit) begin
            r_to <= '0;
        end else begin
            r_to <= r_to + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Reported results of the last completed frame
    // ------------------------------------------------------------------
    logic [11:0] r_h_total, r_v_total;
    logic [10:0] r_h_active, r_v_active;
    logic [31:0] r_pix_sum;
    logic [15:0] r_frame_count;
    logic        r_frame_done;

    // Latch results and pulse frame_done when a measured frame closes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_total     <= 12'd0;
            r_v_total     <= 12'd0;
            r_h_active    <= 11'd0;
            r_v_active    <= 11'd0;
            r_pix_sum     <= 32'd0;
            r_frame_count <= 16'd0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= w_close;
            if (w_close) begin
                r_h_total     <= w_cl_htot;
                r_v_total     <= r_f_vtot;
                r_h_active    <= w_cl_hact;
                r_v_active    <= w_cl_vact;
                r_pix_sum     <= r_f_sum;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign h_total     = r_h_total;
    assign v_total     = r_v_total;
    assign h_active    = r_h_active;
    assign v_active    = r_v_active;
    assign pix_sum     = r_pix_sum;
    assign frame_count = r_frame_count;
    assign frame_done  = r_frame_done;
    assign locked      = (r_state == c_ST_LOCKED);
    assign err         = r_err;

endmodule
`default_nettype wire

// File: doc/mtl_frame_monitor.md
MTL_FRAME_MONITOR -- requirements
Module: mtl_frame_monitor

Interface
REQ-001 Parameter EXP_H_ACTIVE, default 800: expected DE-high pixels per line.
REQ-002 Parameter EXP_V_ACTIVE, default 480: expected lines containing DE per frame.
REQ-003 Parameter LOCK_FRAMES, default 2: consecutive good, identical frames required for lock (range 1-15).
REQ-004 Parameter SYNC_ACT_LOW, default 1: HS/VS asserted when low; 0 = asserted when high.
REQ-005 clk  in  1  single clock; pixel-rate and synchronous with all video inputs.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 hs, vs, de  in  1 each  MTL horizontal sync, vertical sync, data enable.
REQ-008 r, g, b  in  8 each  pixel colour, valid when de=1.
REQ-009 h_total, v_total  out  12 each  clocks per line / lines per frame, last completed frame.
REQ-010 h_active, v_active  out  11 each  DE pixels per line / DE lines, last completed frame.
REQ-011 pix_sum  out  32  checksum of last completed frame.
REQ-012 frame_count  out  16  completed frames since reset, wraps 65535->0.
REQ-013 frame_done  out  1  one-cycle pulse when the above update.
REQ-014 locked  out  1  high in LOCKED state.
REQ-015 err  out  1  sticky; set on loss of lock; cleared only by reset.

Function
REQ-016 Sync normalisation: hs_a/vs_a = input XOR SYNC_ACT_LOW; previous-sample registers reset to deasserted.
REQ-017 Leading edge = asserted in current sample, deasserted in previous sample; a sync held asserted through reset release gives no edge.
REQ-018 Line = HS leading edge to next HS leading edge; line clock count includes the edge cycle.
REQ-019 Frame = VS leading edge to next VS leading edge; v_total counts HS leading edges in that span, an HS edge coincident with the VS edge belongs to the new frame.
REQ-020 DE line count = de=1 cycles within a line; v_active counts lines with nonzero DE count.
REQ-021 Frame is inconsistent if any two nonzero per-line DE counts differ, or any two complete-line clock counts differ.
REQ-022 pix_sum = sum of {r,g,b} as 24-bit unsigned over all de=1 cycles of the frame, modulo 2^32.
REQ-023 All counters saturate at all-ones (12-bit: 4095, 11-bit: 2047), never wrap, except frame_count.
REQ-024 Coincident HS and VS edges: closing line accumulated into the closing frame first, then frame closes, then the new line opens.
REQ-025 On a VS leading edge, except the first after reset, outputs REQ-009..REQ-012 update and frame_done pulses, both visible the cycle after the edge-sampling cycle.
REQ-026 The first VS edge after reset only opens a frame: no frame_done, no counter update.
REQ-027 Frame "good" = consistent, h_active==EXP_H_ACTIVE, v_active==EXP_V_ACTIVE.
REQ-028 State SEARCH: entered from reset; moves to MEASURE on the first VS edge.
REQ-029 State MEASURE: runs a match counter; good frame identical in all four timing values to the previous good frame increments it, otherwise reset it to 1 if good, 0 if not; counter reaching LOCK_FRAMES moves to LOCKED.
REQ-030 With LOCK_FRAMES=1, the first good frame locks.
REQ-031 State LOCKED: locked=1; a frame that is not good or differs in any timing value from the locking frame sets err, drops locked in the same cycle as frame_done, and moves to MEASURE with the match counter reset to 0.
REQ-032 No VS edge for 2^22 clocks in MEASURE or LOCKED returns to SEARCH; err is set if the state was LOCKED.

Reset
REQ-033 Reset asserted: all outputs 0, state SEARCH, all counters and accumulators 0, effective immediately (asynchronous).
REQ-034 Reset mid-frame discards the partial frame; the first VS edge after release behaves per REQ-026.

Verification
REQ-035 Parameters 12/6/LOCK_FRAMES=2, frames with h_total 20, h_active 12, v_total 10, v_active 6, r=1,g=0,b=0: second frame_done shows 20/10/12/6, pix_sum=0x00480000; locked=1 after the third frame_done.
REQ-036 After lock, one frame with a 13-pixel DE on a single line: on that frame_done, locked=0, err=1, state MEASURE; two clean frames later locked=1, err stays 1.
REQ-037 Coincident HS and VS edges every frame: v_total=10, not 9 or 11.
REQ-038 Stop VS for 2^22 clocks while locked: state SEARCH, locked=0, err=1, no frame_done.
REQ-039 Assert reset mid-line while locked: outputs 0 the same cycle; after release, first frame_done appears at the second VS edge with frame_count=1.
REQ-040 Line of 5000 clocks: h_total=4095 (saturated), frame not good, locked stays 0.
